// File: rtl/fft8_frame_sequencer.sv
// Frame controller for the 8-point FFT/IFFT core: gathers 8 serial complex samples,
// holds them as a parallel frame while the core runs, then streams the result out.
module fft8_frame_sequencer #(
  parameter int DW       = 9,
  parameter int N        = 8,
  parameter int CORE_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_re,
  input  logic [DW-1:0]   in_im,
  input  logic            in_mode,
  output logic [N*DW-1:0] core_re,
  output logic [N*DW-1:0] core_im,
  output logic            core_mode,
  output logic            core_start,
  input  logic [N*DW-1:0] core_out_re,
  input  logic [N*DW-1:0] core_out_im,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_re,
  output logic [DW-1:0]   out_im,
  output logic            out_last,
  output logic            busy,
  output logic            frame_done
);

  localparam int RW = (CORE_LAT < 1) ? 1 : $clog2(CORE_LAT + 1);
  localparam logic [RW-1:0] RUN_LAST = RW'(CORE_LAT);
  localparam logic [2:0]    IDX_LAST = 3'd7;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_RUN     = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [2:0]           in_idx_r;
  logic [2:0]           out_idx_r;
  logic [RW-1:0]        run_cnt_r;
  logic [N-1:0][DW-1:0] buf_re_r;
  logic [N-1:0][DW-1:0] buf_im_r;
  logic [N-1:0][DW-1:0] res_re_r;
  logic [N-1:0][DW-1:0] res_im_r;
  logic                 mode_r;
  logic                 start_r;
  logic                 done_r;
  logic                 in_ready_s;
  logic                 out_valid_s;
  logic                 in_fire_s;
  logic                 out_fire_s;
  logic                 run_end_s;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_COLLECT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and handshake strobes; flush gates both handshakes and forces COLLECT
  always_comb begin
    state_nxt_s = state_r;
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    in_fire_s   = 1'b0;
    out_fire_s  = 1'b0;
    run_end_s   = 1'b0;
    case (state_r)
      ST_COLLECT: begin
        in_ready_s = ~flush;
        in_fire_s  = in_valid & ~flush;
        if (flush) begin
          state_nxt_s = ST_COLLECT;
        end else if (in_fire_s && (in_idx_r == IDX_LAST)) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_COLLECT;
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_nxt_s = ST_COLLECT;
        end else if (run_cnt_r == RUN_LAST) begin
          run_end_s   = 1'b1;
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        out_valid_s = ~flush;
        out_fire_s  = out_ready & ~flush;
        if (flush) begin
          state_nxt_s = ST_COLLECT;
        end else if (out_fire_s && (out_idx_r == IDX_LAST)) begin
          state_nxt_s = ST_COLLECT;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_COLLECT;
      end
    endcase
  end

  // Indices, run timer, frame/result buffers and the one-cycle pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_idx_r  <= 3'd0;
      out_idx_r <= 3'd0;
      run_cnt_r <= {RW{1'b0}};
      buf_re_r  <= {(N*DW){1'b0}};
      buf_im_r  <= {(N*DW){1'b0}};
      res_re_r  <= {(N*DW){1'b0}};
      res_im_r  <= {(N*DW){1'b0}};
      mode_r    <= 1'b0;
      start_r   <= 1'b0;
      done_r    <= 1'b0;
    end else if (flush) begin
      in_idx_r  <= 3'd0;
      out_idx_r <= 3'd0;
      run_cnt_r <= {RW{1'b0}};
      start_r   <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      start_r <= in_fire_s && (in_idx_r == IDX_LAST);
      done_r  <= out_fire_s && (out_idx_r == IDX_LAST);
      if (in_fire_s) begin
        buf_re_r[in_idx_r] <= in_re;
        buf_im_r[in_idx_r] <= in_im;
        in_idx_r           <= in_idx_r + 3'd1;
        if (in_idx_r == 3'd0) begin
          mode_r <= in_mode;
        end
      end
      // Timer restarts at 0 on every RUN entry; the last RUN edge captures the core result
      if (state_r == ST_RUN) begin
        run_cnt_r <= run_end_s ? {RW{1'b0}} : run_cnt_r + {{(RW-1){1'b0}}, 1'b1};
      end else begin
        run_cnt_r <= {RW{1'b0}};
      end
      if (run_end_s) begin
        res_re_r <= core_out_re;
        res_im_r <= core_out_im;
      end
      if (out_fire_s) begin
        out_idx_r <= out_idx_r + 3'd1;
      end
    end
  end

  assign in_ready   = in_ready_s & ~rst;
  assign out_valid  = out_valid_s;
  assign core_re    = buf_re_r;
  assign core_im    = buf_im_r;
  assign core_mode  = mode_r;
  assign core_start = start_r;
  assign frame_done = done_r;
  assign busy       = (state_r == ST_RUN) || (state_r == ST_DRAIN);
  assign out_re     = res_re_r[out_idx_r];
  assign out_im     = res_im_r[out_idx_r];
  assign out_last   = (state_r == ST_DRAIN) && (out_idx_r == IDX_LAST);

endmodule

// File: doc/fft8_frame_sequencer.md
Name: fft8_frame_sequencer

Overview:
- Frame controller for the 8-point FFT/IFFT core. The core takes 8 parallel complex 9-bit inputs and produces 8 parallel outputs one clock later (registered).
- Collects 8 serial complex samples over a valid/ready stream and presents them to the core as a stable parallel frame with a per-frame mode select.
- Captures the core result and streams it out serially with valid/ready/last.
- Single frame buffer: input is stalled while a frame is in the core or draining.

Parameters:
- DW, 9, sample component width (signed two's complement)
- N, 8, points per frame; fixed at 8, counters sized for it
- CORE_LAT, 1, core input-to-registered-output latency in clocks (≥1)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous abort; discard current frame
- in_valid  input  1  input sample valid
- in_ready  output  1  sequencer can accept a sample
- in_re  input  DW  input sample real part
- in_im  input  DW  input sample imaginary part
- in_mode  input  1  0=FFT, 1=IFFT; sampled with sample 0 of each frame
- core_re  output  N*DW  parallel real inputs to core; slice k = bits [k*DW +: DW]
- core_im  output  N*DW  parallel imaginary inputs to core
- core_mode  output  1  mode for the frame in the core
- core_start  output  1  one-cycle pulse on the first RUN cycle
- core_out_re  input  N*DW  core registered real outputs, same slicing
- core_out_im  input  N*DW  core registered imaginary outputs
- out_valid  output  1  output sample valid
- out_ready  input  1  downstream accepts
- out_re  output  DW  output sample real part
- out_im  output  DW  output sample imaginary part
- out_last  output  1  high with output sample index 7
- busy  output  1  high in RUN or DRAIN
- frame_done  output  1  one-cycle pulse after the last output transfer

Behaviour:
- Reset (async, rst=1):
  - State = COLLECT; in_idx=0; out_idx=0.
  - Input buffer, result buffer, core_mode, core_start and frame_done are all 0.
  - in_ready=1 once rst deasserts. All other outputs are 0.
- COLLECT:
  - in_ready = ~flush.
  - A transfer occurs when in_valid & in_ready. On a transfer: buffer[in_idx] ← {in_re, in_im}, and in_idx increments.
  - On the transfer at in_idx=0, core_mode ← in_mode. in_mode on samples 1–7 is ignored.
  - On the transfer at in_idx=7: in_idx→0, state→RUN.
- RUN:
  - Lasts exactly CORE_LAT+1 cycles, timed by a run counter.
  - core_re/core_im are driven directly from the input buffer and stay stable throughout RUN and DRAIN.
  - core_start=1 in the first RUN cycle only.
  - On the clock edge ending the last RUN cycle, core_out_re/core_out_im are captured into the result buffer and state→DRAIN.
- DRAIN:
  - out_valid = ~flush. out_re/out_im = result[out_idx]. out_last = (out_idx==7).
  - On out_valid & out_ready, out_idx increments.
  - Outputs hold stable while out_ready=0.
  - On the transfer at out_idx=7: out_idx→0, state→COLLECT, frame_done=1 for the next cycle, and in_ready rises in that same cycle.
- Latency: last input transfer at edge T → first out_valid in cycle T+CORE_LAT+2 (T+3 at default).
- Throughput: one frame per 8 + (CORE_LAT+1) + 8 cycles, with no back-pressure.
- flush (synchronous, any state):
  - Next state = COLLECT; in_idx, out_idx and the run counter are cleared; core_start=0; frame_done is not pulsed.
  - in_ready and out_valid are gated low in the flush cycle, so no transfer happens in that cycle.
  - The buffer contents are left as-is but are considered invalid.
- Widths: data is moved unchanged; no arithmetic or scaling is done in this block.
- Reset mid-frame: behaves exactly as the reset state. A partial frame is lost and no out_valid is produced.
- Mode: core_mode holds from the sample-0 transfer until the next frame's sample-0 transfer.

Test Plan:
- Bench core stub: one-cycle register, core_out_re[k] = core_re[k]+1, core_out_im[k] = core_im[k].
- Single frame: in_re = 10,20,…,80, in_im = 0..7, in_mode=1, both valids/readies held high.
  - Expect core_mode=1 and core_start pulsing 1 cycle after sample 7.
  - Expect out_re = 11,21,…,81 and out_im = 0..7, with out_last only on the 8th output.
  - Expect the first out_valid 3 cycles after the last input edge, and frame_done 1 cycle after the last output.
- Back-pressure:
  - out_ready toggling 1,0,0,1… → no sample is lost or duplicated and out_re is stable while stalled.
  - in_valid gaps of 2 cycles during COLLECT → frame is still assembled correctly.
- Stall input: present a 9th sample during RUN/DRAIN → in_ready=0 and the sample is accepted only after frame_done, as sample 0 of the next frame.
- Flush:
  - Flush after 5 input samples → in_ready=1 the next cycle, and the next 8 samples form a clean frame (outputs match that frame only).
  - Flush in DRAIN at out_idx=3 → out_valid=0 the next cycle and no frame_done.
- Async reset mid-DRAIN: assert rst between edges → out_valid drops immediately, all outputs are 0, and in_ready=1 after release.
- Mode per frame: frame A with mode=0, frame B with mode=1, and in_mode toggled on non-zero samples → core_mode = 0 then 1, unaffected by the toggles.
